axi_lite_arb2: RTL and testbench
================================

# axi_lite_arb2

Two-master AXI4-Lite arbiter that shares one downstream AXI4-Lite slave port (the UART / memory-mapped device bus) between instruction fetch (m0) and load/store (m1). It grants one complete transaction at a time, read or write, and forwards it to the slave. It routes the response back to the owning master. It releases the bus only after the response handshake.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports; STRB_W = DATA_W/8

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- mN_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address, master N ∈ {0,1}
- mN_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/STRB_W/1/1  write data, master N
- mN_bresp/bvalid/bready  out/out/in  2/1/1  write response, master N
- mN_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address, master N
- mN_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data, master N
- s_*  mirror set of all five channels toward the slave; directions inverted

## Operation
- State register: IDLE, RADDR, RDATA, WADDR, WRESP. A 1-bit `owner` register and a 1-bit `last` register support it.
- Request: master N requests when mN_arvalid | mN_awvalid. Inside one master, a pending read wins over a pending write.
- Arbitration in IDLE, round-robin:
  - A single requester wins.
  - If both masters request, the winner is the master ≠ last.
  - On the grant, owner and last are loaded with the winner.
  - The next state is RADDR or WADDR.
- RADDR: s_ar* = owner's ar*, and owner's arready = s_arready. On the s_ar handshake the state moves to RDATA.
- RDATA: owner's r* = s_r*, and s_rready = owner's rready. On the s_r handshake the state moves to IDLE.
- WADDR:
  - AW and W forward independently.
  - aw_done and w_done latch their respective handshakes, and each channel's valid is gated off once its done flag is set.
  - When both are done, or both handshake in the same cycle, the state moves to WRESP and both flags clear.
- WRESP: owner's b* = s_b*, and s_bready = owner's bready. On the s_b handshake the state moves to IDLE.
- Non-owner: all ready and valid outputs are 0, and its data outputs are 0.
- rresp and bresp pass through unmodified; SLVERR is not altered.
- All channel forwarding is combinational from state, owner and inputs. The arbiter holds no data buffering.

## Timing
- Reset values:
  - state = IDLE, last = 1 (so m0 wins the first tie), owner = 0, aw_done = w_done = 0.
  - Every s_* valid/ready output and every mN_* ready/valid output is 0.
  - Data and resp outputs are 0.
- Arbitration costs one bubble cycle. A request seen in IDLE at edge k is forwarded on s_ar/s_aw from cycle k+1.
- Minimum read occupancy is 3 cycles (IDLE, RADDR, RDATA) with a zero-wait slave. Minimum write occupancy is 3 cycles (IDLE, WADDR, WRESP).
- A request arriving while the bus is busy waits. Its valid must stay asserted per AXI, and the arbiter never drops it.
- Back-to-back: after a response handshake the state is IDLE for one cycle, and a waiting master wins if it differs from last.
- Reset mid-transaction: the state returns to IDLE immediately. Forwarded valids drop the same cycle, and no response is delivered for the aborted transaction.
- No combinational path from s_* inputs to s_* outputs.

## Structure
- Shared package npc_axi_pkg:
  - the arb_state_t enum (IDLE, RADDR, RDATA, WADDR, WRESP);
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
- One sub-module, rr_arb2: inputs req[1:0], last; output grant index and valid. It is purely combinational and used in IDLE.
- Top module: state, owner, last and done flags, plus the channel muxes.

## Test plan
- Reset, then no requests → all valids/readies 0 for 10 cycles, and state stays IDLE.
- m0 read 0x8000_0000, slave returns 0x1234_5678 after 2 wait cycles → m0_rdata = 0x1234_5678 with rresp 00. m1 sees no activity.
- m0 arvalid and m1 awvalid+wvalid (addr 0xA000_03F8, data 0x41) in the same cycle → m0 is served first. m1's write then reaches s_aw/s_w, and m1 gets bvalid with bresp 00. last = 1.
- Both masters issue reads continuously for 6 transactions → grants alternate m0, m1, m0, …, and no master is granted twice in a row.
- m1 write with s_awready = 1 but s_wready delayed 3 cycles → s_awvalid drops after the AW handshake, and s_wvalid holds until the W handshake. Exactly one B is forwarded.
- rst asserted during RDATA of an m1 read → the same cycle, m1_rvalid = 0 and s_rready = 0. After release, m0's read completes normally.

Source files
------------

// File: rtl/npc_axi_pkg.sv
// Shared AXI4-Lite definitions for the NPC bus fabric: arbiter state encoding
// and response codes.
package npc_axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arb2_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie, the master that
// did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       grant_vld
);

  // Combinational winner selection, consulted only while the bus is idle
  always_comb begin
    grant_vld = |req;
    grant     = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master AXI4-Lite arbiter. Owns the downstream slave for one complete
// read or write transaction at a time and releases it after the response
// handshake. All forwarding is combinational from state/owner; no buffering.
module axi_lite_arb2
  import npc_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic [1:0]        m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1 (load/store)
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // shared slave port
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  arb_state_t state;
  logic       owner;
  logic       last;
  logic       aw_done;
  logic       w_done;

  logic [1:0] req;
  logic       grant;
  logic       grant_vld;
  logic       win_rd;
  logic       aw_hs;
  logic       w_hs;

  assign req[0] = m0_arvalid | m0_awvalid;
  assign req[1] = m1_arvalid | m1_awvalid;

  // A master with both a read and a write pending is serviced read-first
  assign win_rd = grant ? m1_arvalid : m0_arvalid;

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .last      (last),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  // Transaction sequencer: grant, address phase(s), response, release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner <= grant;
            last  <= grant;
            state <= win_rd ? RADDR : WADDR;
          end
        end
        RADDR: if (s_arvalid && s_arready) state <= RDATA;
        RDATA: if (s_rvalid && s_rready) state <= IDLE;
        WADDR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WRESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: if (s_bvalid && s_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Channel muxes: connect only the owner's channels for the active phase
  always_comb begin
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m0_awready = 1'b0; m0_wready = 1'b0; m0_bresp = '0; m0_bvalid = 1'b0;
    m0_arready = 1'b0; m0_rdata = '0; m0_rresp = '0; m0_rvalid = 1'b0;
    m1_awready = 1'b0; m1_wready = 1'b0; m1_bresp = '0; m1_bvalid = 1'b0;
    m1_arready = 1'b0; m1_rdata = '0; m1_rresp = '0; m1_rvalid = 1'b0;
    case (state)
      RADDR: begin
        s_araddr  = owner ? m1_araddr  : m0_araddr;
        s_arvalid = owner ? m1_arvalid : m0_arvalid;
        if (owner) m1_arready = s_arready;
        else       m0_arready = s_arready;
      end
      RDATA: begin
        s_rready = owner ? m1_rready : m0_rready;
        if (owner) begin
          m1_rdata = s_rdata; m1_rresp = s_rresp; m1_rvalid = s_rvalid;
        end else begin
          m0_rdata = s_rdata; m0_rresp = s_rresp; m0_rvalid = s_rvalid;
        end
      end
      WADDR: begin
        s_awaddr  = owner ? m1_awaddr : m0_awaddr;
        s_awvalid = (owner ? m1_awvalid : m0_awvalid) & ~aw_done;
        s_wdata   = owner ? m1_wdata  : m0_wdata;
        s_wstrb   = owner ? m1_wstrb  : m0_wstrb;
        s_wvalid  = (owner ? m1_wvalid : m0_wvalid) & ~w_done;
        if (owner) begin
          m1_awready = s_awready & ~aw_done;
          m1_wready  = s_wready & ~w_done;
        end else begin
          m0_awready = s_awready & ~aw_done;
          m0_wready  = s_wready & ~w_done;
        end
      end
      WRESP: begin
        s_bready = owner ? m1_bready : m0_bready;
        if (owner) begin
          m1_bresp = s_bresp; m1_bvalid = s_bvalid;
        end else begin
          m0_bresp = s_bresp; m0_bvalid = s_bvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: idle after reset, single read with wait
// states, read/write tie, alternating read stream, split AW/W write, and
// reset during a read data phase.
module tb_axi_lite_arb2;
  import npc_axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [1:0]  m0_bresp, m0_rresp;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [1:0]  m1_bresp, m1_rresp;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;

  int checks = 0;
  int errors = 0;
  int bcount;
  logic any_hs;

  always #5 clk = ~clk;

  axi_lite_arb2 dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0;
    m0_bready = 0; m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0;
    m1_bready = 0; m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    settle();
    // ---- reset values
    chk("rst_state", dut.state, IDLE);
    chk("rst_last", dut.last, 1'b1);
    chk("rst_owner", dut.owner, 1'b0);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_m0_arready", m0_arready, 1'b0);
    do_reset();

    // ---- idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      any_hs = s_arvalid | s_awvalid | s_wvalid | s_rready | s_bready |
               m0_arready | m0_awready | m0_wready | m0_rvalid | m0_bvalid |
               m1_arready | m1_awready | m1_wready | m1_rvalid | m1_bvalid;
      chk("idle_quiet", any_hs, 1'b0);
      chk("idle_state", dut.state, IDLE);
      step();
    end

    // ---- m0 read with two slave wait cycles
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1;
    settle();
    chk("rd_bubble_arvalid", s_arvalid, 1'b0);
    step();
    chk("rd_s_arvalid", s_arvalid, 1'b1);
    chk("rd_s_araddr", s_araddr, 32'h8000_0000);
    s_arready = 1; settle();
    chk("rd_m0_arready", m0_arready, 1'b1);
    chk("rd_m1_arready", m1_arready, 1'b0);
    step();
    m0_arvalid = 0; s_arready = 0;
    chk("rd_state_rdata", dut.state, RDATA);
    for (int i = 0; i < 2; i++) begin
      chk("rd_wait_rvalid", m0_rvalid, 1'b0);
      step();
    end
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = AXI_RESP_OKAY; settle();
    chk("rd_m0_rvalid", m0_rvalid, 1'b1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m0_rresp", m0_rresp, AXI_RESP_OKAY);
    chk("rd_s_rready", s_rready, 1'b1);
    chk("rd_m1_rvalid", m1_rvalid, 1'b0);
    chk("rd_m1_rdata", m1_rdata, 32'h0);
    step();
    s_rvalid = 0; s_rdata = '0;
    chk("rd_back_idle", dut.state, IDLE);
    chk("rd_m0_rvalid_off", m0_rvalid, 1'b0);

    // ---- tie: m0 read vs m1 write; m0 wins after reset
    do_reset();
    m0_araddr = 32'h0000_1000; m0_arvalid = 1; m0_rready = 1;
    m1_awaddr = 32'hA000_03F8; m1_awvalid = 1; m1_wdata = 32'h41; m1_wstrb = 4'hF;
    m1_wvalid = 1; m1_bready = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'hCAFE_0001; s_awready = 1; s_wready = 1;
    s_bvalid = 1; s_bresp = AXI_RESP_OKAY;
    settle();
    chk("tie_bubble_ar", s_arvalid, 1'b0);
    chk("tie_bubble_aw", s_awvalid, 1'b0);
    step();
    chk("tie_m0_first", s_arvalid, 1'b1);
    chk("tie_no_aw", s_awvalid, 1'b0);
    chk("tie_m1_awready", m1_awready, 1'b0);
    step();
    m0_arvalid = 0; settle();
    chk("tie_m0_rvalid", m0_rvalid, 1'b1);
    chk("tie_m0_rdata", m0_rdata, 32'hCAFE_0001);
    step();
    chk("tie_idle_gap", dut.state, IDLE);
    chk("tie_idle_aw", s_awvalid, 1'b0);
    step();
    chk("tie_s_awvalid", s_awvalid, 1'b1);
    chk("tie_s_awaddr", s_awaddr, 32'hA000_03F8);
    chk("tie_s_wvalid", s_wvalid, 1'b1);
    chk("tie_s_wdata", s_wdata, 32'h41);
    chk("tie_m1_wready", m1_wready, 1'b1);
    chk("tie_m0_awready", m0_awready, 1'b0);
    step();
    m1_awvalid = 0; m1_wvalid = 0; settle();
    chk("tie_wresp_aw", s_awvalid, 1'b0);
    chk("tie_m1_bvalid", m1_bvalid, 1'b1);
    chk("tie_m1_bresp", m1_bresp, AXI_RESP_OKAY);
    chk("tie_s_bready", s_bready, 1'b1);
    chk("tie_last", dut.last, 1'b1);
    step();
    chk("tie_end_idle", dut.state, IDLE);
    chk("tie_m1_bvalid_off", m1_bvalid, 1'b0);
    clear_inputs();

    // ---- continuous reads from both masters alternate
    m0_araddr = 32'h0000_0100; m0_arvalid = 1; m0_rready = 1;
    m1_araddr = 32'h0000_0200; m1_arvalid = 1; m1_rready = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h0000_BEEF;
    settle();
    for (int i = 0; i < 6; i++) begin
      chk("rr_idle", dut.state, IDLE);
      step();
      chk("rr_owner", dut.owner, i[0]);
      chk("rr_araddr", s_araddr, (i[0] ? 32'h0000_0200 : 32'h0000_0100));
      chk("rr_other_arready", (i[0] ? m0_arready : m1_arready), 1'b0);
      step();
      chk("rr_rvalid", (i[0] ? m1_rvalid : m0_rvalid), 1'b1);
      step();
    end
    clear_inputs();
    settle();

    // ---- m1 write, AW accepted immediately, W delayed 3 cycles
    m1_awaddr = 32'h0000_0040; m1_awvalid = 1; m1_wdata = 32'h0000_00AA; m1_wstrb = 4'h1;
    m1_wvalid = 1; m1_bready = 1; s_awready = 1; s_wready = 0;
    settle();
    step();
    chk("sw_aw_first", s_awvalid, 1'b1);
    chk("sw_w_first", s_wvalid, 1'b1);
    step();
    chk("sw_aw_gated", s_awvalid, 1'b0);
    chk("sw_awready_gated", m1_awready, 1'b0);
    chk("sw_w_hold1", s_wvalid, 1'b1);
    step();
    chk("sw_w_hold2", s_wvalid, 1'b1);
    chk("sw_aw_gated2", s_awvalid, 1'b0);
    s_wready = 1; settle();
    chk("sw_m1_wready", m1_wready, 1'b1);
    step();
    m1_awvalid = 0; m1_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bresp = AXI_RESP_SLVERR;
    settle();
    chk("sw_state_wresp", dut.state, WRESP);
    chk("sw_bresp_slverr", m1_bresp, AXI_RESP_SLVERR);
    bcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (m1_bvalid) bcount++;
      step();
    end
    chk("sw_one_b", bcount, 1);
    clear_inputs();
    settle();

    // ---- reset during m1 read data phase
    m1_araddr = 32'h0000_0300; m1_arvalid = 1; m1_rready = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h0BAD_0BAD;
    settle();
    step();
    step();
    m1_arvalid = 0; settle();
    chk("rr_m1_rvalid_pre", m1_rvalid, 1'b1);
    rst = 1; settle();
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_mid_state", dut.state, IDLE);
    step();
    rst = 0;
    m0_araddr = 32'h0000_0500; m0_arvalid = 1; m0_rready = 1; s_rdata = 32'h5555_AAAA;
    settle();
    chk("post_rst_m1_rvalid", m1_rvalid, 1'b0);
    step();
    chk("post_rst_araddr", s_araddr, 32'h0000_0500);
    step();
    m0_arvalid = 0; settle();
    chk("post_rst_m0_rdata", m0_rdata, 32'h5555_AAAA);
    chk("post_rst_m0_rvalid", m0_rvalid, 1'b1);
    step();
    chk("post_rst_idle", dut.state, IDLE);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
